// File: rtl/id_stage_fwd.sv
// MIPS32 decode stage for logic/shift instructions: decodes inst_i, reads the register
// file, forwards EX/MEM results over RAW hazards and holds the result in a handshaked ID/EX register.
module id_stage_fwd #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned ALUOP_W  = 8,
    parameter int unsigned ALUSEL_W = 3,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [31:0]         inst_i,
    output logic                reg1_read_o,
    output logic [4:0]          reg1_addr_o,
    input  logic [31:0]         reg1_data_i,
    output logic                reg2_read_o,
    output logic [4:0]          reg2_addr_o,
    input  logic [31:0]         reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic [4:0]          ex_wd_i,
    input  logic [31:0]         ex_wdata_i,
    input  logic                mem_wreg_i,
    input  logic [4:0]          mem_wd_i,
    input  logic [31:0]         mem_wdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [PC_W-1:0]     pc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [31:0]         reg1_o,
    output logic [31:0]         reg2_o,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic                illegal_o
);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL = 8'h7C;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;

    typedef enum logic [1:0] {
        SEL_NOP   = 2'd0,
        SEL_LOGIC = 2'd1,
        SEL_SHIFT = 2'd2
    } alusel_t;

    typedef struct packed {
        logic        legal;
        logic        rd1;
        logic        rd2;
        logic [31:0] imm1;
        logic [31:0] imm2;
        logic [4:0]  wd;
        logic [7:0]  aluop;
        alusel_t     alusel;
    } dec_t;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  funct;
    logic [15:0] imm;
    dec_t        dec;
    logic [31:0] operand1, operand2;
    logic        accept;

    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign sa     = inst_i[10:6];
    assign funct  = inst_i[5:0];
    assign imm    = inst_i[15:0];

    // Undecodable encodings keep the all-zero default: no reads, zero operands, wd=0, NOP.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        dec = '{legal: 1'b0, rd1: 1'b0, rd2: 1'b0, imm1: 32'h0, imm2: 32'h0,
                wd: 5'd0, aluop: OP_NOP, alusel: SEL_NOP};
        case (opcode)
            6'h00: begin
                if (sa == 5'd0 && funct[5:2] == 4'b1001) begin
                    dec.legal  = 1'b1;
                    dec.rd1    = 1'b1;
                    dec.rd2    = 1'b1;
                    dec.wd     = rd;
                    dec.alusel = SEL_LOGIC;
                    case (funct[1:0])
                        2'd0:    dec.aluop = OP_AND;
                        2'd1:    dec.aluop = OP_OR;
                        2'd2:    dec.aluop = OP_XOR;
                        default: dec.aluop = OP_NOR;
                    endcase
                end else if (sa == 5'd0 && (funct == 6'h04 || funct == 6'h06 || funct == 6'h07)) begin
                    dec.legal  = 1'b1;
                    dec.rd1    = 1'b1;
                    dec.rd2    = 1'b1;
                    dec.wd     = rd;
                    dec.alusel = SEL_SHIFT;
                    dec.aluop  = (funct == 6'h04) ? OP_SLL : (funct == 6'h06) ? OP_SRL : OP_SRA;
                end else if (rs == 5'd0 && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
                    dec.legal  = 1'b1;
                    dec.rd2    = 1'b1;
                    dec.imm1   = {27'b0, sa};
                    dec.wd     = rd;
                    dec.alusel = SEL_SHIFT;
                    dec.aluop  = (funct == 6'h00) ? OP_SLL : (funct == 6'h02) ? OP_SRL : OP_SRA;
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec.legal  = 1'b1;
                dec.rd1    = 1'b1;
                dec.imm2   = {16'h0, imm};
                dec.wd     = rt;
                dec.alusel = SEL_LOGIC;
                dec.aluop  = (opcode == 6'h0C) ? OP_AND : (opcode == 6'h0D) ? OP_OR : OP_XOR;
            end
            6'h0F: begin
                if (rs == 5'd0) begin
                    // Port 1 reads r0, which always resolves to zero: OR 0 with {imm,0}.
                    dec.legal  = 1'b1;
                    dec.rd1    = 1'b1;
                    dec.imm2   = {imm, 16'h0};
                    dec.wd     = rt;
                    dec.alusel = SEL_LOGIC;
                    dec.aluop  = OP_OR;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] resolve_operand(
        input logic        rd_en,
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic [31:0] imm_val,
        input logic        exw,
        input logic [4:0]  exd,
        input logic [31:0] exdata,
        input logic        memw,
        input logic [4:0]  memd,
        input logic [31:0] memdata
    );
        if (!rd_en)
            return imm_val;
        if (addr == 5'd0)
            return 32'h0;
        // EX holds the younger result, so it wins over MEM for the same register.
        if (FWD_EN && exw && exd == addr)
            return exdata;
        if (FWD_EN && memw && memd == addr)
            return memdata;
        return rf_data;
    endfunction

    always_comb begin
        operand1 = resolve_operand(dec.rd1, rs, reg1_data_i, dec.imm1,
                                   ex_wreg_i, ex_wd_i, ex_wdata_i,
                                   mem_wreg_i, mem_wd_i, mem_wdata_i);
        operand2 = resolve_operand(dec.rd2, rt, reg2_data_i, dec.imm2,
                                   ex_wreg_i, ex_wd_i, ex_wdata_i,
                                   mem_wreg_i, mem_wd_i, mem_wdata_i);
    end

    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;
    assign reg1_read_o = in_valid_i && !rst && dec.rd1;
    assign reg2_read_o = in_valid_i && !rst && dec.rd2;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            out_valid_o <= 1'b0;
            pc_o        <= '0;
            aluop_o     <= '0;
            alusel_o    <= '0;
            reg1_o      <= 32'h0;
            reg2_o      <= 32'h0;
            wd_o        <= 5'd0;
            wreg_o      <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            pc_o        <= pc_i;
            aluop_o     <= ALUOP_W'(dec.aluop);
            alusel_o    <= ALUSEL_W'(dec.alusel);
            reg1_o      <= operand1;
            reg2_o      <= operand2;
            wd_o        <= dec.wd;
            // Writes to r0 are dropped so SLL r0,r0,0 behaves as a true NOP.
            wreg_o      <= dec.legal && (dec.wd != 5'd0);
            illegal_o   <= !dec.legal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed literal cases, then randomized traffic compared every
// cycle against a mnemonic-level reference model of the decode stage.
module tb_id_stage_fwd;

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid_i, in_ready_o;
    logic [31:0] pc_i, inst_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] pc_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wd_o;
    logic        wreg_o, illegal_o;

    int vectors = 0;
    int miscompares = 0;
    bit compare_on = 1'b0;

    always #5 clk = ~clk;

    id_stage_fwd #(.PC_W(32), .ALUOP_W(8), .ALUSEL_W(3), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
        .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 60)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum { K_RLOG, K_VSH, K_SH, K_ILOG, K_LUI, K_BAD } kind_t;

    function automatic kind_t classify(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00 && w[10:6] == 5'd0 && fn >= 6'h24 && fn <= 6'h27) return K_RLOG;
        if (op == 6'h00 && w[10:6] == 5'd0 && (fn == 6'h04 || fn == 6'h06 || fn == 6'h07)) return K_VSH;
        if (op == 6'h00 && w[25:21] == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) return K_SH;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return K_ILOG;
        if (op == 6'h0F && w[25:21] == 5'd0) return K_LUI;
        return K_BAD;
    endfunction

    // Value a register would have in EX this cycle, given the current bypass inputs.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'h0;
        if (ex_wreg_i && ex_wd_i == r) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == r) return mem_wdata_i;
        return rf;
    endfunction

    function automatic logic [7:0] shift_code(input logic [1:0] kind_bits);
        // 00 -> left, 10 -> logical right, 11 -> arithmetic right
        if (kind_bits == 2'b00) return 8'h7C;
        if (kind_bits == 2'b10) return 8'h02;
        return 8'h03;
    endfunction

    logic        m_valid = 1'b0, m_wreg = 1'b0, m_illegal = 1'b0;
    logic [31:0] m_pc = 0, m_reg1 = 0, m_reg2 = 0;
    logic [7:0]  m_aluop = 0;
    logic [2:0]  m_alusel = 0;
    logic [4:0]  m_wd = 0;

    always @(posedge clk) begin
        kind_t k;
        logic  ready;
        ready = !m_valid || out_ready_i;
        k = classify(inst_i);
        if (rst || flush_i) begin
            m_valid = 0; m_pc = 0; m_aluop = 0; m_alusel = 0;
            m_reg1 = 0; m_reg2 = 0; m_wd = 0; m_wreg = 0; m_illegal = 0;
        end else if (in_valid_i && ready) begin
            m_valid = 1;
            m_pc = pc_i;
            m_illegal = (k == K_BAD);
            m_aluop = 8'h00; m_alusel = 3'd0; m_reg1 = 0; m_reg2 = 0; m_wd = 0;
            case (k)
                K_RLOG: begin
                    m_aluop = {2'b00, inst_i[5:0]};
                    m_alusel = 3'd1;
                    m_reg1 = reg_value(inst_i[25:21], reg1_data_i);
                    m_reg2 = reg_value(inst_i[20:16], reg2_data_i);
                    m_wd = inst_i[15:11];
                end
                K_VSH: begin
                    m_aluop = shift_code(inst_i[1:0]);
                    m_alusel = 3'd2;
                    m_reg1 = reg_value(inst_i[25:21], reg1_data_i);
                    m_reg2 = reg_value(inst_i[20:16], reg2_data_i);
                    m_wd = inst_i[15:11];
                end
                K_SH: begin
                    m_aluop = shift_code(inst_i[1:0]);
                    m_alusel = 3'd2;
                    m_reg1 = 32'(inst_i[10:6]);
                    m_reg2 = reg_value(inst_i[20:16], reg2_data_i);
                    m_wd = inst_i[15:11];
                end
                K_ILOG: begin
                    m_aluop = (inst_i[27:26] == 2'b00) ? 8'h24 : (inst_i[27:26] == 2'b01) ? 8'h25 : 8'h26;
                    m_alusel = 3'd1;
                    m_reg1 = reg_value(inst_i[25:21], reg1_data_i);
                    m_reg2 = {16'h0, inst_i[15:0]};
                    m_wd = inst_i[20:16];
                end
                K_LUI: begin
                    m_aluop = 8'h25;
                    m_alusel = 3'd1;
                    m_reg1 = 32'h0;
                    m_reg2 = {inst_i[15:0], 16'h0};
                    m_wd = inst_i[20:16];
                end
                default: ;
            endcase
            m_wreg = (k != K_BAD) && (m_wd != 5'd0);
        end else if (out_ready_i) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        kind_t k;
        if (compare_on) begin
            k = classify(inst_i);
            check("out_valid", 64'(out_valid_o), 64'(m_valid));
            check("in_ready", 64'(in_ready_o), 64'(!m_valid || out_ready_i));
            check("pc", 64'(pc_o), 64'(m_pc));
            check("aluop", 64'(aluop_o), 64'(m_aluop));
            check("alusel", 64'(alusel_o), 64'(m_alusel));
            check("reg1", 64'(reg1_o), 64'(m_reg1));
            check("reg2", 64'(reg2_o), 64'(m_reg2));
            check("wd", 64'(wd_o), 64'(m_wd));
            check("wreg", 64'(wreg_o), 64'(m_wreg));
            check("illegal", 64'(illegal_o), 64'(m_illegal));
            check("reg1_read", 64'(reg1_read_o),
                  64'(in_valid_i && !rst && (k == K_RLOG || k == K_VSH || k == K_ILOG || k == K_LUI)));
            check("reg2_read", 64'(reg2_read_o),
                  64'(in_valid_i && !rst && (k == K_RLOG || k == K_VSH || k == K_SH)));
            check("reg1_addr", 64'(reg1_addr_o), 64'(inst_i[25:21]));
            check("reg2_addr", 64'(reg2_addr_o), 64'(inst_i[20:16]));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [4:0] a, input logic [5:0] f);
        return {6'h00, s, t, d, a, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] f;
        case ($urandom_range(0, 9))
            0, 7: return r_type(rreg(), rreg(), rreg(), 5'd0, 6'(6'h24 + $urandom_range(0, 3)));
            1: begin
                f = ($urandom_range(0, 2) == 0) ? 6'h04 : ($urandom_range(0, 1) == 0) ? 6'h06 : 6'h07;
                return r_type(rreg(), rreg(), rreg(), 5'd0, f);
            end
            2, 9: begin
                f = ($urandom_range(0, 2) == 0) ? 6'h00 : ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
                return r_type(5'd0, rreg(), rreg(), 5'($urandom), f);
            end
            3, 8: return i_type(6'(6'h0C + $urandom_range(0, 2)), rreg(), rreg(), 16'($urandom));
            4: return i_type(6'h0F, 5'd0, rreg(), 16'($urandom));
            5: return $urandom;
            default: begin
                case ($urandom_range(0, 2))
                    0: return r_type(rreg(), rreg(), rreg(), 5'd1, 6'h25);
                    1: return r_type(5'd3, rreg(), rreg(), 5'd4, 6'h02);
                    default: return i_type(6'h0F, 5'd2, rreg(), 16'h1234);
                endcase
            end
        endcase
    endfunction

    localparam logic [31:0] ORI_R1_R2   = {6'h0D, 5'd2, 5'd1, 16'h8001};
    localparam logic [31:0] AND_R3_R4_5 = {6'h00, 5'd4, 5'd5, 5'd3, 5'd0, 6'h24};
    localparam logic [31:0] AND_R3_R0_5 = {6'h00, 5'd0, 5'd5, 5'd3, 5'd0, 6'h24};
    localparam logic [31:0] SRA_R6_R7   = {6'h00, 5'd0, 5'd7, 5'd6, 5'd31, 6'h03};
    localparam logic [31:0] LUI_R8      = {6'h0F, 5'd0, 5'd8, 16'hABCD};
    localparam logic [31:0] XOR_R9_1_2  = {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h26};

    initial begin
        rst = 1; flush_i = 0; in_valid_i = 1; inst_i = ORI_R1_R2; pc_i = 32'h100;
        reg1_data_i = 0; reg2_data_i = 0; out_ready_i = 1;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;

        // Reset held two cycles with a valid instruction offered.
        step();
        compare_on = 1;
        step();
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_wreg", 64'(wreg_o), 64'd0);
        check("rst_reg1", 64'(reg1_o), 64'd0);
        check("rst_reg2", 64'(reg2_o), 64'd0);
        check("rst_read1", 64'(reg1_read_o), 64'd0);
        rst = 0;
        #1 check("rst_in_ready", 64'(in_ready_o), 64'd1);

        // ORI r1,r2,0x8001
        reg1_data_i = 32'h0000_00F0;
        step();
        check("ori_aluop", 64'(aluop_o), 64'h25);
        check("ori_alusel", 64'(alusel_o), 64'd1);
        check("ori_reg1", 64'(reg1_o), 64'hF0);
        check("ori_reg2", 64'(reg2_o), 64'h8001);
        check("ori_wd", 64'(wd_o), 64'd1);
        check("ori_wreg", 64'(wreg_o), 64'd1);
        check("ori_pc", 64'(pc_o), 64'h100);

        // AND r3,r4,r5 forwarding priority
        inst_i = AND_R3_R4_5; pc_i = 32'h104;
        reg1_data_i = 32'h99; reg2_data_i = 32'h77;
        ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = 32'h11;
        mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h22;
        step();
        check("fwd_ex_over_mem", 64'(reg1_o), 64'h11);
        check("fwd_rt_regfile", 64'(reg2_o), 64'h77);
        check("and_aluop", 64'(aluop_o), 64'h24);
        check("and_wd", 64'(wd_o), 64'd3);
        mem_wd_i = 5; mem_wdata_i = 32'h33;
        step();
        check("fwd_rs_ex", 64'(reg1_o), 64'h11);
        check("fwd_rt_mem", 64'(reg2_o), 64'h33);
        inst_i = AND_R3_R0_5; ex_wd_i = 0; ex_wdata_i = 32'h55;
        step();
        check("fwd_r0_zero", 64'(reg1_o), 64'h0);
        check("fwd_rt_mem2", 64'(reg2_o), 64'h33);
        ex_wreg_i = 0; mem_wreg_i = 0;

        // SRA r6,r7,31 then LUI r8,0xABCD
        inst_i = SRA_R6_R7; reg2_data_i = 32'h8000_0000;
        step();
        check("sra_reg1", 64'(reg1_o), 64'd31);
        check("sra_alusel", 64'(alusel_o), 64'd2);
        check("sra_aluop", 64'(aluop_o), 64'h03);
        check("sra_reg2", 64'(reg2_o), 64'h8000_0000);
        inst_i = LUI_R8;
        step();
        check("lui_reg2", 64'(reg2_o), 64'hABCD_0000);
        check("lui_aluop", 64'(aluop_o), 64'h25);
        check("lui_reg1", 64'(reg1_o), 64'h0);
        check("lui_wd", 64'(wd_o), 64'd8);

        // Stall three cycles with XOR r9,r1,r2 on offer
        out_ready_i = 0; inst_i = XOR_R9_1_2; pc_i = 32'h200;
        #1 check("stall_in_ready", 64'(in_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 64'(out_valid_o), 64'd1);
            check("stall_wd", 64'(wd_o), 64'd8);
            check("stall_reg2", 64'(reg2_o), 64'hABCD_0000);
            check("stall_in_ready2", 64'(in_ready_o), 64'd0);
        end
        out_ready_i = 1;
        step();
        check("release_wd", 64'(wd_o), 64'd9);
        check("release_aluop", 64'(aluop_o), 64'h26);
        check("release_pc", 64'(pc_o), 64'h200);

        // Flush while stalled with a new instruction offered
        out_ready_i = 0; inst_i = ORI_R1_R2; flush_i = 1;
        step();
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_wd", 64'(wd_o), 64'd0);
        flush_i = 0; out_ready_i = 1; inst_i = 32'hFC00_0000;
        step();
        check("ill_illegal", 64'(illegal_o), 64'd1);
        check("ill_wreg", 64'(wreg_o), 64'd0);
        check("ill_valid", 64'(out_valid_o), 64'd1);
        check("ill_aluop", 64'(aluop_o), 64'h00);
        in_valid_i = 0;
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            flush_i     = ($urandom_range(0, 99) < 5);
            in_valid_i  = ($urandom_range(0, 99) < 75);
            out_ready_i = ($urandom_range(0, 99) < 70);
            inst_i      = rand_inst();
            pc_i        = $urandom;
            reg1_data_i = $urandom;
            reg2_data_i = $urandom;
            ex_wreg_i   = $urandom_range(0, 1);
            ex_wd_i     = rreg();
            ex_wdata_i  = $urandom;
            mem_wreg_i  = $urandom_range(0, 1);
            mem_wd_i    = rreg();
            mem_wdata_i = $urandom;
            step();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
